// File: rtl/m_store_buf.sv
// Store buffer: encodes sw/sb/sh into word address, lane-replicated data and byte
// enables, queues them FIFO and presents the head to memory. Define STORE_ALIGN_CHECK_EN to reject misaligned sw/sh.
module m_store_buf #(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     st_valid,
    output logic                     st_ready,
    input  logic [31:0]              st_addr,
    input  logic [31:0]              st_data,
    input  logic [2:0]               st_op,
    output logic                     st_err,
    output logic                     mem_valid,
    input  logic                     mem_ready,
    output logic [31:0]              mem_addr,
    output logic [31:0]              mem_wdata,
    output logic [3:0]               mem_be,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    localparam logic [2:0] OP_SW = 3'b000;
    localparam logic [2:0] OP_SB = 3'b001;
    localparam logic [2:0] OP_SH = 3'b010;

    logic [31:0]   addr_q  [DEPTH];
    logic [31:0]   wdata_q [DEPTH];
    logic [3:0]    be_q    [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          st_err_q, st_err_d;

    logic [31:0]   enc_addr;
    logic [31:0]   enc_wdata;
    logic [3:0]    enc_be;
    logic          enc_legal;
    logic          take;
    logic          push;
    logic          pop;

    always_comb begin
        enc_addr  = {st_addr[31:2], 2'b00};
        enc_wdata = '0;
        enc_be    = '0;
        enc_legal = 1'b0;
        case (st_op)
            OP_SW: begin
                enc_wdata = st_data;
                enc_be    = 4'b1111;
`ifdef STORE_ALIGN_CHECK_EN
                enc_legal = (st_addr[1:0] == 2'b00);
`else
                enc_legal = 1'b1;
`endif
            end
            OP_SB: begin
                enc_wdata = {4{st_data[7:0]}};
                enc_be    = 4'b0001 << st_addr[1:0];
                enc_legal = 1'b1;
            end
            OP_SH: begin
                enc_wdata = {2{st_data[15:0]}};
                enc_be    = st_addr[1] ? 4'b1100 : 4'b0011;
`ifdef STORE_ALIGN_CHECK_EN
                enc_legal = !st_addr[0];
`else
                enc_legal = 1'b1;
`endif
            end
            default: enc_legal = 1'b0;
        endcase
    end

    // Ready depends only on occupancy, so mem_ready never reaches st_ready.
    assign st_ready  = (count_q < FULL);
    assign mem_valid = (count_q != '0);
    assign take      = st_valid && st_ready;
    assign push      = take && enc_legal;
    assign pop       = mem_valid && mem_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        st_err_d = take && !enc_legal;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            st_err_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i]  <= '0;
                wdata_q[i] <= '0;
                be_q[i]    <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            st_err_q <= st_err_d;
            if (push) begin
                addr_q[wr_ptr_q]  <= enc_addr;
                wdata_q[wr_ptr_q] <= enc_wdata;
                be_q[wr_ptr_q]    <= enc_be;
            end
        end
    end

    // Head fields are forced to zero when empty so stale entries never show.
    assign mem_addr  = mem_valid ? addr_q[rd_ptr_q]  : '0;
    assign mem_wdata = mem_valid ? wdata_q[rd_ptr_q] : '0;
    assign mem_be    = mem_valid ? be_q[rd_ptr_q]    : '0;
    assign st_err    = st_err_q;
    assign count     = count_q;

endmodule

// File: tb/tb_m_store_buf.sv
// Directed bench for m_store_buf: expected memory writes go into a queue and a
// negedge monitor compares every accepted write against it.
module tb_m_store_buf;

    localparam int DEPTH = 2;
    localparam int CW = $clog2(DEPTH) + 1;

    logic          clk;
    logic          reset_n;
    logic          st_valid;
    logic          st_ready;
    logic [31:0]   st_addr;
    logic [31:0]   st_data;
    logic [2:0]    st_op;
    logic          st_err;
    logic          mem_valid;
    logic          mem_ready;
    logic [31:0]   mem_addr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_be;
    logic [CW-1:0] count;

    logic [67:0] exp_q[$];
    int n_vec;
    int n_fail;

    m_store_buf #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .st_valid  (st_valid),
        .st_ready  (st_ready),
        .st_addr   (st_addr),
        .st_data   (st_data),
        .st_op     (st_op),
        .st_err    (st_err),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .count     (count)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic exp_push(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
        exp_q.push_back({a, wd, be});
    endtask

    // driver: offer one request for one cycle; caller is aligned at posedge+1
    task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [2:0] op);
        st_valid = 1'b1;
        st_addr  = a;
        st_data  = d;
        st_op    = op;
        @(posedge clk);
        #1;
        st_valid = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        while (exp_q.size() > 0 && k < budget) begin
            step(1);
            k++;
        end
        check("drain_done", 32'(exp_q.size()), 32'd0);
    endtask

    // monitor: a write is accepted at the next posedge when valid && ready
    always @(negedge clk) begin
        logic [67:0] e;
        if (reset_n && mem_valid && mem_ready) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL mem_write_unexpected: got addr 0x%08h wdata 0x%08h be %b, none expected",
                         mem_addr, mem_wdata, mem_be);
            end else begin
                e = exp_q.pop_front();
                if ({mem_addr, mem_wdata, mem_be} !== e) begin
                    n_fail++;
                    $display("FAIL mem_write: got addr 0x%08h wdata 0x%08h be %b expected addr 0x%08h wdata 0x%08h be %b",
                             mem_addr, mem_wdata, mem_be, e[67:36], e[35:4], e[3:0]);
                end
            end
        end
    end

    initial begin
        logic exp_err;
        n_vec     = 0;
        n_fail    = 0;
        reset_n   = 1'b0;
        st_valid  = 1'b0;
        st_addr   = '0;
        st_data   = '0;
        st_op     = '0;
        mem_ready = 1'b0;
        #12;
        check("rst_count", 32'(count), 32'd0);
        check("rst_mem_valid", 32'(mem_valid), 32'd0);
        check("rst_st_err", 32'(st_err), 32'd0);
        check("rst_mem_be", 32'(mem_be), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        reset_n = 1'b1;
        step(1);
        check("rst_st_ready", 32'(st_ready), 32'd1);

        // sb to lane 3, one-cycle latency, no bypass
        mem_ready = 1'b1;
        exp_push(32'h0000_1000, 32'hABAB_ABAB, 4'b1000);
        check("no_bypass", 32'(mem_valid), 32'd0);
        send(32'h0000_1003, 32'h0000_00AB, 3'b001);
        check("sb_latency_valid", 32'(mem_valid), 32'd1);
        check("sb_count1", 32'(count), 32'd1);
        check("sb_no_err", 32'(st_err), 32'd0);
        step(1);
        check("sb_count0", 32'(count), 32'd0);

        // sh upper half then sw back to back: simultaneous push and pop
        exp_push(32'h0000_2000, 32'h1234_1234, 4'b1100);
        send(32'h0000_2002, 32'h0000_1234, 3'b010);
        exp_push(32'h0000_3000, 32'hDEAD_BEEF, 4'b1111);
        send(32'h0000_3000, 32'hDEAD_BEEF, 3'b000);
        check("push_pop_count", 32'(count), 32'd1);
        exp_push(32'h0000_1000, 32'h5555_5555, 4'b0001);
        send(32'h0000_1000, 32'h0000_0055, 3'b001);
        exp_push(32'h0000_2000, 32'hBEEF_BEEF, 4'b0011);
        send(32'h0000_2000, 32'hFFFF_BEEF, 3'b010);
        exp_push(32'h0000_1004, 32'h6666_6666, 4'b0100);
        send(32'h0000_1006, 32'h1234_5666, 3'b001);
        drain(10);

        // fill to DEPTH with memory stalled
        mem_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            exp_push(32'h0000_4000 + 32'(4 * i), 32'hC0DE_0000 + 32'(i), 4'b1111);
            send(32'h0000_4000 + 32'(4 * i), 32'hC0DE_0000 + 32'(i), 3'b000);
        end
        check("full_count", 32'(count), 32'(DEPTH));
        check("full_st_ready", 32'(st_ready), 32'd0);
        st_valid = 1'b1;
        st_addr  = 32'h0000_5000;
        st_data  = 32'h9999_9999;
        st_op    = 3'b000;
        step(3);
        check("full_offer_ignored", 32'(count), 32'(DEPTH));
        check("stall_addr", mem_addr, 32'h0000_4000);
        check("stall_wdata", mem_wdata, 32'hC0DE_0000);
        check("stall_be", 32'(mem_be), 32'hF);
        // pop while full with st_valid high: no push on that edge
        mem_ready = 1'b1;
        step(1);
        st_valid  = 1'b0;
        mem_ready = 1'b0;
        check("full_pop_count", 32'(count), 32'(DEPTH - 1));
        check("full_pop_ready", 32'(st_ready), 32'd1);
        mem_ready = 1'b1;
        drain(10);

        // reserved op with one entry queued
        mem_ready = 1'b0;
        exp_push(32'h0000_6000, 32'h0BAD_F00D, 4'b1111);
        send(32'h0000_6000, 32'h0BAD_F00D, 3'b000);
        send(32'h0000_7000, 32'h1111_1111, 3'b011);
        check("rsv_err_pulse", 32'(st_err), 32'd1);
        check("rsv_count", 32'(count), 32'd1);
        step(1);
        check("rsv_err_clear", 32'(st_err), 32'd0);
        send(32'h0000_7000, 32'h1111_1111, 3'b111);
        check("rsv7_err_pulse", 32'(st_err), 32'd1);
        check("rsv7_count", 32'(count), 32'd1);
        mem_ready = 1'b1;
        drain(10);

        // misaligned sh / sw
`ifdef STORE_ALIGN_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
        exp_push(32'h0000_0000, 32'hA5A5_A5A5, 4'b0011);
        exp_push(32'h0000_3000, 32'h0102_0304, 4'b1111);
`endif
        send(32'h0000_0001, 32'h0000_A5A5, 3'b010);
        check("misalign_sh_err", 32'(st_err), 32'(exp_err));
        send(32'h0000_3002, 32'h0102_0304, 3'b000);
        check("misalign_sw_err", 32'(st_err), 32'(exp_err));
        drain(10);

        // reset with two entries queued
        mem_ready = 1'b0;
        send(32'h0000_8000, 32'h8888_8888, 3'b000);
        send(32'h0000_8004, 32'h7777_7777, 3'b000);
        check("pre_rst_count", 32'(count), 32'd2);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(mem_valid), 32'd0);
        check("async_rst_count", 32'(count), 32'd0);
        check("async_rst_be", 32'(mem_be), 32'd0);
        #3;
        reset_n   = 1'b1;
        mem_ready = 1'b1;
        step(6);
        check("post_rst_count", 32'(count), 32'd0);
        check("post_rst_ready", 32'(st_ready), 32'd1);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/m_store_buf.md
M_STORE_BUF -- requirements
Module: m_store_buf

Interface
REQ-001 SHALL have parameter DEPTH, default 2, store-buffer entries (power of two, 2..8).
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port st_valid  input  1  store request offered.
REQ-005 SHALL have port st_ready  output  1  buffer can accept a request.
REQ-006 SHALL have port st_addr  input  32  byte address of store.
REQ-007 SHALL have port st_data  input  32  store data, right-justified.
REQ-008 SHALL have port st_op  input  3  000 sw, 001 sb, 010 sh; others reserved.
REQ-009 SHALL have port st_err  output  1  one-cycle pulse: dropped illegal or misaligned store.
REQ-010 SHALL have port mem_valid  output  1  head entry presented to memory.
REQ-011 SHALL have port mem_ready  input  1  memory takes head entry.
REQ-012 SHALL have port mem_addr  output  32  word address, bits [1:0] forced 00.
REQ-013 SHALL have port mem_wdata  output  32  lane-replicated write data.
REQ-014 SHALL have port mem_be  output  4  byte enables, bit i = byte lane i.
REQ-015 SHALL have port count  output  log2(DEPTH)+1  current occupancy.

Function
REQ-016 SHALL assert st_ready exactly when count < DEPTH; no combinational path from mem_ready to st_ready.
REQ-017 SHALL treat a request as taken on a clk edge with st_valid && st_ready.
REQ-018 SHALL encode sw: be 1111, wdata = st_data.
REQ-019 SHALL encode sb: be = 0001 shifted left by st_addr[1:0], wdata = st_data[7:0] replicated x4.
REQ-020 SHALL encode sh: be = 0011 when st_addr[1]=0, 1100 when 1; wdata = st_data[15:0] replicated x2.
REQ-021 SHALL drop (not enqueue) a taken request with reserved st_op and pulse st_err high the following cycle.
REQ-022 SHALL enqueue legal taken requests in FIFO order with addr, wdata, be stored per entry.
REQ-023 SHALL drive mem_valid = (count != 0) and mem_addr/mem_wdata/mem_be from the head entry, all from registers.
REQ-024 SHALL pop the head on a clk edge with mem_valid && mem_ready; outputs hold stable while mem_valid && !mem_ready.
REQ-025 SHALL present a store to an empty buffer on mem_* one cycle after it is taken (no bypass).
REQ-026 SHALL keep count unchanged on simultaneous push and pop; pointers wrap modulo DEPTH.
REQ-027 SHALL ignore mem_ready when count = 0 and st_valid when st_ready = 0.
REQ-028 SHALL drive mem_be, mem_wdata, mem_addr to zero while count = 0.

Reset
REQ-029 SHALL on reset_n low clear count, pointers, st_err, mem_valid, mem_addr, mem_wdata, mem_be to 0 immediately; st_ready high after release.
REQ-030 SHALL discard all buffered entries on reset mid-operation; none issued after release.

Configuration
REQ-031 SHALL honour macro STORE_ALIGN_CHECK_EN: defined -> sh with st_addr[0]=1 or sw with st_addr[1:0]!=00 is dropped with st_err pulse.
REQ-032 SHALL without STORE_ALIGN_CHECK_EN ignore misaligned low bits (sh uses st_addr[1] only, sw uses 00) and never raise st_err for alignment.

Verification
REQ-033 SHALL check: sb addr 0x1003 data 0x000000AB, mem_ready=1 -> next cycle mem_addr 0x1000, be 1000, wdata 0xABABABAB, then count 0.
REQ-034 SHALL check: sh addr 0x2002 data 0x1234 -> be 1100, wdata 0x12341234; sw 0x3000 0xDEADBEEF -> be 1111.
REQ-035 SHALL check: mem_ready=0, push DEPTH stores -> st_ready 0, 3rd offer ignored, outputs stable; mem_ready=1 -> drained in order.
REQ-036 SHALL check: full buffer, mem_ready=1 and st_valid=1 same cycle -> one pop, no push, count DEPTH-1 next cycle.
REQ-037 SHALL check: st_op 011 -> st_err pulse 1 cycle, count unchanged; with STORE_ALIGN_CHECK_EN, sh addr 0x0001 -> st_err, without -> be 0011.
REQ-038 SHALL check: reset_n low with 2 entries queued -> mem_valid 0 and count 0 asynchronously, no write after release.
